pwm_duty_ramp: RTL and testbench

- Upstream duty-cycle source for the PWM generator. Its `duty` output drives the PWM `duty` input directly.
- Accepts a target duty through a valid/ready handshake.
- Slews its registered `duty` output toward the target by a programmable step, once every programmable number of clocks.
- Gives soft-start, soft-stop and "breathing" behaviour without abrupt duty jumps.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/ramp_prescaler.sv | 35 +++
 rtl/pwm_duty_ramp.sv | 141 ++++++++++++++
 tb/tb_pwm_duty_ramp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-ramp block.
// Optional mid-ramp retargeting is enabled by defining PWM_RAMP_RETARGET_EN.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

  localparam int R_DEF      = 8;
  localparam int RATE_W_DEF = 16;

  function automatic int duty_max(input int r);
    return int'(32'd1 << r);
  endfunction

endpackage

// File: rtl/ramp_prescaler.sv
// Step-interval counter: raises tick once every rate+1 running clocks and
// holds its count while run is low.
module ramp_prescaler #(
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              run,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [RATE_W-1:0] cnt_r;

  assign tick = run && (cnt_r == rate);

  // Interval counter, wraps to zero on each tick
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (run) begin
      if (tick) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + {{(RATE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slews a registered PWM duty toward a handshaked target by a programmable step
// per programmable interval. Define PWM_RAMP_RETARGET_EN to accept targets mid-ramp.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int R      = R_DEF,
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [R:0]        target,
  input  logic              target_valid,
  output logic              target_ready,
  input  logic [R:0]        step,
  input  logic [RATE_W-1:0] rate,
  output logic [R:0]        duty,
  output logic              busy,
  output logic              done
);

  localparam logic [R:0] DMAX = (R+1)'(duty_max(R));
  localparam logic [R:0] ONE  = {{R{1'b0}}, 1'b1};

  ramp_state_t       state_r;
  logic [R:0]        tgt_r;
  logic [R:0]        step_r;
  logic [RATE_W-1:0] rate_r;
  logic [R:0]        duty_r;
  logic              busy_r;
  logic              done_r;

  logic              accept_s;
  logic              run_s;
  logic              tick_s;
  logic [R:0]        tgt_clamp_s;
  logic [R:0]        step_eff_s;
  logic [R+1:0]      diff_up_s;
  logic [R+1:0]      diff_dn_s;

`ifdef PWM_RAMP_RETARGET_EN
  assign target_ready = enable;
`else
  assign target_ready = enable && (state_r == IDLE);
`endif

  assign accept_s = target_valid && target_ready;
  assign run_s    = enable && (state_r != IDLE);
  assign duty     = duty_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Clamp, zero-step substitution and widened distance to target
  always_comb begin
    tgt_clamp_s = target;
    step_eff_s  = step_r;
    if (target > DMAX) begin
      tgt_clamp_s = DMAX;
    end else begin
      tgt_clamp_s = target;
    end
    if (step_r == {(R+1){1'b0}}) begin
      step_eff_s = ONE;
    end else begin
      step_eff_s = step_r;
    end
    diff_up_s = {1'b0, tgt_r} - {1'b0, duty_r};
    diff_dn_s = {1'b0, duty_r} - {1'b0, tgt_r};
  end

  ramp_prescaler #(.RATE_W(RATE_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (accept_s),
    .run   (run_s),
    .rate  (rate_r),
    .tick  (tick_s)
  );

  // Ramp FSM; an accepted target takes priority over a pending tick
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      tgt_r   <= '0;
      step_r  <= '0;
      rate_r  <= '0;
      duty_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        tgt_r  <= tgt_clamp_s;
        step_r <= step;
        rate_r <= rate;
        if (tgt_clamp_s > duty_r) begin
          state_r <= RAMP_UP;
          busy_r  <= 1'b1;
        end else if (tgt_clamp_s < duty_r) begin
          state_r <= RAMP_DOWN;
          busy_r  <= 1'b1;
        end else begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
      end else if (tick_s) begin
        case (state_r)
          RAMP_UP: begin
            // Final step lands exactly on the target, never beyond it
            if (diff_up_s <= {1'b0, step_eff_s}) begin
              duty_r  <= tgt_r;
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              duty_r <= duty_r + step_eff_s;
            end
          end
          RAMP_DOWN: begin
            if (diff_dn_s <= {1'b0, step_eff_s}) begin
              duty_r  <= tgt_r;
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              duty_r <= duty_r - step_eff_s;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: directed and random ramps checked
// against a closed-form trajectory model (duty after n active clocks).
module tb_pwm_duty_ramp;

  localparam int R      = 8;
  localparam int RATE_W = 16;
  localparam int DMAX   = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [R:0]        target;
  logic              target_valid;
  logic              target_ready;
  logic [R:0]        step;
  logic [RATE_W-1:0] rate;
  logic [R:0]        duty;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  // Model of the current ramp: start point, clamped target, effective step
  int m_duty, m_start, m_tc, m_se, m_rate, m_dist, n_done;
  bit m_up;

  pwm_duty_ramp #(.R(R), .RATE_W(RATE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .step         (step),
    .rate         (rate),
    .duty         (duty),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Duty after n enabled clocks since the target was accepted
  function automatic int exp_duty(input int n);
    int mv;
    mv = m_se * (n / (m_rate + 1));
    if (mv > m_dist) mv = m_dist;
    return m_up ? m_start + mv : m_start - mv;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    target_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_duty", 32'(duty), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    m_duty = 0;
  endtask

  // Called right after a falling edge; returns right after a falling edge
  task automatic issue(input int t, input int s, input int r);
    chk("ready_before_accept", 32'(target_ready), 1);
    target = 9'(t);
    step = 9'(s);
    rate = 16'(r);
    target_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    target_valid = 1'b0;
    m_start = m_duty;
    m_tc = (t > DMAX) ? DMAX : t;
    m_se = (s == 0) ? 1 : s;
    m_rate = r;
    m_up = (m_tc > m_start);
    m_dist = m_up ? m_tc - m_start : m_start - m_tc;
    n_done = ((m_dist + m_se - 1) / m_se) * (r + 1);
  endtask

  task automatic track(input int drop_at, input int drop_len, input int rst_at, input int stop_at);
    int n;
    bit fin;
    n = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      chk("duty", 32'(duty), 32'(exp_duty(n)));
      chk("busy", 32'(busy), (n < n_done) ? 1 : 0);
      chk("done", 32'(done), (n == n_done) ? 1 : 0);
      if (n == n_done) begin
        @(negedge clk);
        chk("done_single", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("final_duty", 32'(duty), 32'(m_tc));
        m_duty = m_tc;
        fin = 1'b1;
      end else if (n == stop_at) begin
        m_duty = exp_duty(n);
        fin = 1'b1;
      end else if (n == rst_at) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_duty", 32'(duty), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(target_ready), 1);
        m_duty = 0;
        fin = 1'b1;
      end else begin
        if (n == drop_at) begin
          for (int d = 0; d < drop_len; d++) begin
            enable = 1'b0;
            target_valid = 1'b1;
            target = 9'($urandom_range(0, 256));
            @(posedge clk);
            @(negedge clk);
            chk("hold_duty", 32'(duty), 32'(exp_duty(n)));
            chk("hold_busy", 32'(busy), 1);
            chk("hold_done", 32'(done), 0);
            chk("hold_ready", 32'(target_ready), 0);
          end
          enable = 1'b1;
          target_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        n++;
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    target_valid = 1'b0;
    target = '0;
    step = '0;
    rate = '0;
    m_duty = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_duty", 32'(duty), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_disabled", 32'(target_ready), 0);
    enable = 1'b1;
    #1;
    chk("ready_enabled", 32'(target_ready), 1);
    @(negedge clk);

    // Non-multiple step up then down: 10,20,25 then 15,5,3
    issue(25, 10, 0);
    track(-1, 0, -1, -1);
    issue(3, 10, 0);
    track(-1, 0, -1, -1);

    // 0 -> 100 by 10 every 4 clocks, with a 5-clock enable drop mid-ramp
    do_reset();
    issue(100, 10, 3);
    track(17, 5, -1, -1);

    // Clamp to full scale, then an equal target
    issue(300, 7, 1);
    track(-1, 0, -1, -1);
    issue(256, 5, 0);
    track(-1, 0, -1, -1);

    // Reset while ramping, at duty 60
    do_reset();
    issue(200, 20, 0);
    track(-1, 0, 3, -1);

    for (int i = 0; i < 6; i++) begin
      issue(int'($urandom_range(0, 300)), int'($urandom_range(0, 60)), int'($urandom_range(0, 4)));
      if (n_done > 4) track(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), -1, -1);
      else track(-1, 0, -1, -1);
    end

`ifdef PWM_RAMP_RETARGET_EN
    // Reverse mid-ramp at duty 80 toward 40
    do_reset();
    issue(200, 20, 0);
    track(-1, 0, -1, 4);
    issue(40, 10, 0);
    track(-1, 0, -1, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
